// File: rtl/conv_mac_unit.sv
// rtl/conv_mac_unit.sv - self-sequenced convolution multiply-accumulate engine
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; discards any partial result
//   start      begin a new result (IDLE only); samples bias
//   bias       signed bias, same Q format as the operands
//   in_valid   idata/kernel pair present
//   in_ready   pair accepted this cycle (ACC state only)
//   idata      signed pixel
//   kernel     signed weight
//   busy       high in ACC, FLUSH and OUT
//   out_valid  one-cycle pulse, cdata_out valid
//   cdata_out  rounded, saturated (optionally ReLU'd) result; held until next pulse

module conv_mac_unit #(
    parameter int DATA_W  = 20,
    parameter int FRAC_W  = 16,
    parameter int TAPS    = 9,
    parameter int RELU_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] idata,
    input  logic [DATA_W-1:0] kernel,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] cdata_out
);

    // Wide enough for TAPS worst-case products plus the shifted bias.
    localparam int ACC_W  = 2 * DATA_W + $clog2(TAPS) + 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    // Saturation bounds expressed in accumulator width for signed compares.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                     start_go;
    logic                     out_load;
    logic                     handshake;
    logic                     last_tap;

    logic signed [PROD_W-1:0] prod_full;
    logic signed [PROD_W-1:0] prod_q;
    logic                     prod_v;
    logic [CNT_W-1:0]         tap_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] bias_q;

    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W-1:0]  rounded;
    logic                     round_bit;
    logic [DATA_W-1:0]        sat_val;
    logic [DATA_W-1:0]        result;

    assign handshake = in_valid && in_ready;
    assign last_tap  = handshake && (tap_cnt == LAST_TAP);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ACC;
            S_ACC:   if (last_tap) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State decode outputs; in_ready has no path from in_valid.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        start_go = 1'b0;
        out_load = 1'b0;
        case (state)
            S_IDLE:  start_go = start;
            S_ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_FLUSH: busy = 1'b1;
            S_OUT: begin
                busy     = 1'b1;
                out_load = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply / accumulate datapath
    // ------------------------------------------------------------------
    assign prod_full = $signed(idata) * $signed(kernel);
    assign prod_ext  = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};

    // ------------------------------------------------------------------
    // Bias, round half-up, saturate, optional ReLU
    // ------------------------------------------------------------------
    assign bias_ext = {{(ACC_W - DATA_W){bias_q[DATA_W-1]}}, bias_q};
    assign sum      = acc + (bias_ext <<< FRAC_W);
    assign shifted  = sum >>> FRAC_W;

    generate
        if (FRAC_W > 0) begin : g_round
            assign round_bit = sum[FRAC_W-1];
        end else begin : g_no_round
            assign round_bit = 1'b0;
        end
    endgenerate

    assign rounded = shifted + $signed({{(ACC_W - 1){1'b0}}, round_bit});

    always_comb begin
        sat_val = rounded[DATA_W-1:0];
        if (rounded > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (rounded < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end
    end

    always_comb begin
        result = sat_val;
        if ((RELU_EN != 0) && sat_val[DATA_W-1]) begin
            result = '0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            prod_q    <= '0;
            prod_v    <= 1'b0;
            tap_cnt   <= '0;
            bias_q    <= '0;
            out_valid <= 1'b0;
            cdata_out <= '0;
        end else begin
            out_valid <= 1'b0;
            if (start_go) begin
                acc     <= '0;
                bias_q  <= $signed(bias);
                tap_cnt <= '0;
                prod_v  <= 1'b0;
            end else begin
                // A product registered on one cycle is folded in on the next,
                // so the final tap lands during FLUSH.
                prod_v <= handshake;
                if (handshake) begin
                    prod_q  <= prod_full;
                    tap_cnt <= tap_cnt + 1'b1;
                end
                if (prod_v) begin
                    acc <= acc + prod_ext;
                end
            end
            if (out_load) begin
                cdata_out <= result;
                out_valid <= 1'b1;
            end
        end
    end

endmodule
